cond_logic: RTL and testbench
=============================

# cond_logic

Condition and flag unit for the multicycle ARM datapath; it consumes the `{N,Z,C,V}` flags produced by `alu` and decides whether the current instruction may commit. It holds the architectural NZCV register and evaluates the instruction's 4-bit condition field against it. It registers the condition result so that later FSM states can use it, and it gates the controller's raw write requests into the final `PCWrite`, `RegWrite` and `MemWrite` enables.

## Interface
- `RESET_FLAGS`, default `4'b0000`: NZCV value loaded on reset.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `Cond`, input, 4: instruction condition field `Instr[31:28]`.
- `ALUFlags`, input, 4: `{N,Z,C,V}` from `alu`. Bit 3 is N, bit 0 is V.
- `FlagW`, input, 2: flag-write request. `[1]` updates N,Z; `[0]` updates C,V.
- `PCS`, input, 1: instruction writes PC (branch, or Rd=R15).
- `NextPC`, input, 1: FSM fetch-state PC increment. This is unconditional.
- `RegW`, input, 1: raw register-write request from the FSM.
- `MemW`, input, 1: raw memory-write request from the FSM.
- `NoWrite`, input, 1: compare-class instruction (CMP/CMN/TST). It suppresses the register write.
- `PCWrite`, output, 1: gated PC write enable.
- `RegWrite`, output, 1: gated register-file write enable.
- `MemWrite`, output, 1: gated memory write enable.
- `CondEx`, output, 1: combinational condition result against the current flags.
- `Flags`, output, 4: current registered NZCV.

## Operation
- **`CondEx`** is decoded from `Cond` and the registered `Flags`. It never uses `ALUFlags` directly. Codes:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C & !Z
  - LS 1001: !C | Z
  - GE 1010: N == V
  - LT 1011: N != V
  - GT 1100: !Z & (N == V)
  - LE 1101: Z | (N != V)
  - AL 1110: 1
  - 1111: 0 (treated as never; no write enable may assert)
- **`FlagWrite[1:0]`** = `FlagW & {2{CondEx}}`. A suppressed instruction never changes the flags.
- **Flag update** on each rising edge:
  - If `FlagWrite[1]`, `Flags[3:2]` ← `ALUFlags[3:2]`.
  - If `FlagWrite[0]`, `Flags[1:0]` ← `ALUFlags[1:0]`.
  - The two halves are updated independently.
- **`CondExR`** is loaded with `CondEx` on every rising edge. It holds the decision made in the execute state for use in the following memory and writeback states.
- **Gated enables:**
  - `RegWrite` = `RegW & CondExR & !NoWrite`
  - `MemWrite` = `MemW & CondExR`
  - `PCWrite` = `(PCS & CondExR) | NextPC`

## Timing
- **Reset:** while `reset` is high at a rising edge:
  - `Flags` ← `RESET_FLAGS`.
  - `CondExR` ← 0.
  - In the cycle after reset, `RegWrite`, `MemWrite` and the `PCS` term of `PCWrite` are therefore 0.
- **Flag latency:** a flag write is visible on `Flags` and `CondEx` one cycle after the edge that samples it.
- **Same-cycle evaluation:** an instruction whose flag-setting and evaluation fall in the same cycle evaluates against the pre-update flags.
- **Gating latency:** gated enables follow `CondEx` with one cycle of latency through `CondExR`. This matches the multicycle FSM, where execute precedes writeback.
- **`NextPC`** passes through combinationally, with zero latency, regardless of `CondExR`.
- **Reset mid-instruction:** a pending `CondExR` is discarded and no late write escapes.
- **Both `FlagW` bits high with `CondEx`=0:** no flag bit changes.
- **Don't-care inputs:** `ALUFlags` values are ignored whenever the corresponding `FlagWrite` bit is low. X on `ALUFlags` must not propagate to `Flags` in that case.

## Structure
- **Package `arm_pkg`:**
  - `cond_e` enum with the 16 codes above (EQ … AL, NV).
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `ALUControl` encodings: `ALU_ADD=2'b00`, `ALU_SUB=2'b01`, `ALU_AND=2'b10`, `ALU_ORR=2'b11`.
- **Sub-module `cond_check`:** purely combinational; inputs `Cond` and `Flags`, output `CondEx`. Instantiated once.
- **Registers:** the flag registers and the `CondExR` register live in `cond_logic` itself.

## Test plan
- **Reset then ADD:**
  - Stimulus: assert `reset` 1 cycle; then `Cond`=1110, `FlagW`=11, `ALUFlags`=0000 (0xA+0x5=0xF).
  - Required: `Flags`=0000 after reset and still 0000 after the write; `RegW`=1 gives `RegWrite`=1 the next cycle.
- **SUB sets carry, then HI:**
  - Stimulus: `FlagW`=11, `ALUFlags`=0010 (0xA−0x5=5); next cycle `Cond`=1000.
  - Required: `Flags`=0010, `CondEx`=1.
- **SUB 5−5 then EQ vs NE:**
  - Stimulus: `ALUFlags`=0110 written; then `Cond`=0000, then `Cond`=0001, with `MemW`=1.
  - Required: `CondEx`=1 for EQ and 0 for NE; `MemWrite` is 1 the cycle after EQ and 0 after NE.
- **Suppressed instruction:**
  - Stimulus: `Flags`=0000, `Cond`=0000 (EQ false), `FlagW`=11, `ALUFlags`=1111, `PCS`=1, `NextPC`=0.
  - Required: `Flags` stays 0000; `PCWrite`=0 the next cycle. With `NextPC`=1, `PCWrite`=1 in that same cycle.
- **Partial flag write and CMP:**
  - Stimulus: `Flags`=0000, `FlagW`=10, `ALUFlags`=1011. Then `NoWrite`=1, `RegW`=1, `Cond`=1110.
  - Required: `Flags`=1000 (C,V untouched); `RegWrite`=0.
- **Reset mid-operation and code 1111:**
  - Stimulus: `CondExR`=1 with `RegW`=1, then `reset` pulses. Separately, apply `Cond`=1111 with `FlagW`=11.
  - Required: after the reset pulse, `RegWrite`=0 the next cycle and `Flags`=`RESET_FLAGS`. With `Cond`=1111, `CondEx`=0 and `Flags` are unchanged.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and constants for the multicycle ARM datapath.
// Condition codes, NZCV bit positions and ALU control encodings.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an instruction condition field
// against the architectural NZCV flags.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;
  logic ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~c | z;
      GE: CondEx = ge;
      LT: CondEx = ~ge;
      GT: CondEx = ~z & ge;
      LE: CondEx = z | ~ge;
      AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register, registered condition result and
// commit gating of the controller's raw write requests.
module cond_logic
  import arm_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] flag_write;
  logic       cond_ex_r;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign flag_write = FlagW & {2{CondEx}};

  // Halves load independently; ALUFlags is only sampled when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags     <= RESET_FLAGS;
      cond_ex_r <= 1'b0;
    end else begin
      if (flag_write[1])
        Flags[3:2] <= ALUFlags[3:2];
      if (flag_write[0])
        Flags[1:0] <= ALUFlags[1:0];
      cond_ex_r <= CondEx;
    end
  end

  assign RegWrite = RegW & cond_ex_r & ~NoWrite;
  assign MemWrite = MemW & cond_ex_r;
  assign PCWrite  = (PCS & cond_ex_r) | NextPC;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table
// followed by randomized stimulus against a reference model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  localparam logic [3:0] RST_F = 4'b0000;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_flags;
  logic       m_cexr;

  always #5 clk = ~clk;

  cond_logic #(.RESET_FLAGS(RST_F)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       nowr;
    logic [3:0] e_flags;
    logic       e_cex;
    logic       e_pcw;
    logic       e_rw;
    logic       e_mw;
  } vec_t;

  vec_t tv[$];

  // ARM rule: odd codes invert the predicate of the even code below
  function automatic logic ref_cond(logic [3:0] code, logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (code[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return code[0] ? !base : base;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    reset    = t.rst;
    Cond     = t.cond;
    ALUFlags = t.alu;
    FlagW    = t.fw;
    PCS      = t.pcs;
    NextPC   = t.npc;
    RegW     = t.regw;
    MemW     = t.memw;
    NoWrite  = t.nowr;
  endtask

  task automatic model_edge();
    logic       ce;
    logic [3:0] nf;
    ce = ref_cond(Cond, m_flags);
    nf = m_flags;
    if (FlagW[1] && ce) nf[3:2] = ALUFlags[3:2];
    if (FlagW[0] && ce) nf[1:0] = ALUFlags[1:0];
    @(posedge clk);
    if (reset) begin
      m_flags = RST_F;
      m_cexr  = 1'b0;
    end else begin
      m_flags = nf;
      m_cexr  = ce;
    end
    #1;
  endtask

  task automatic model_check(string tag);
    check({tag, ".flags"}, Flags, m_flags);
    check({tag, ".condex"}, {3'b0, CondEx},
          {3'b0, ref_cond(Cond, m_flags)});
    check({tag, ".regwrite"}, {3'b0, RegWrite},
          {3'b0, RegW & m_cexr & !NoWrite});
    check({tag, ".memwrite"}, {3'b0, MemWrite},
          {3'b0, MemW & m_cexr});
    check({tag, ".pcwrite"}, {3'b0, PCWrite},
          {3'b0, (PCS & m_cexr) | NextPC});
  endtask

  initial begin
    vec_t r;
    // rst cond alu fw pcs npc regw memw nowr | flags cex pcw rw mw
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'h8, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0010, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0010, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   4'b0110, 1'b1, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'h1, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   4'b0110, 1'b0, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                   4'b0110, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0110, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'h0, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b1, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                   4'b1000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   4'b1000, 1'b1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   4'b1000, 1'b1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hF, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                   4'b0000, 1'b0, 1'b1, 1'b1, 1'b1});
    tv.push_back('{1'b0, 4'hF, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'bxxxx, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});

    r = '{1'b1, 4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(r);
    m_flags = 4'bxxxx;
    m_cexr  = 1'bx;
    #1;
    model_edge();

    for (int i = 0; i < tv.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tv[i]);
      #1;
      check({tag, ".flags"}, Flags, tv[i].e_flags);
      check({tag, ".condex"}, {3'b0, CondEx}, {3'b0, tv[i].e_cex});
      check({tag, ".pcwrite"}, {3'b0, PCWrite}, {3'b0, tv[i].e_pcw});
      check({tag, ".regwrite"}, {3'b0, RegWrite}, {3'b0, tv[i].e_rw});
      check({tag, ".memwrite"}, {3'b0, MemWrite}, {3'b0, tv[i].e_mw});
      model_edge();
    end

    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 31) == 0);
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      PCS      = 1'($urandom_range(0, 1));
      NextPC   = ($urandom_range(0, 3) == 0);
      RegW     = 1'($urandom_range(0, 1));
      MemW     = 1'($urandom_range(0, 1));
      NoWrite  = ($urandom_range(0, 3) == 0);
      #1;
      model_check($sformatf("rnd%0d", i));
      model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
